// File: rtl/ft64_amo_pkg.sv
// Shared definitions for the FT64 AMO sequencer: op codes, size and fault
// encodings, FSM states, and the lane helpers used by the bus-side logic.
package ft64_amo_pkg;

   typedef enum logic [4:0] {
      AMO_SWAP = 5'h00,
      AMO_ADD  = 5'h01,
      AMO_AND  = 5'h02,
      AMO_OR   = 5'h03,
      AMO_XOR  = 5'h04,
      AMO_SHL  = 5'h05,
      AMO_SHR  = 5'h06,
      AMO_MIN  = 5'h08,
      AMO_MAX  = 5'h09,
      AMO_MINU = 5'h0A,
      AMO_MAXU = 5'h0B
   } amo_op_t;

   localparam logic [1:0] SZ_BYTE  = 2'd0;
   localparam logic [1:0] SZ_WYDE  = 2'd1;
   localparam logic [1:0] SZ_TETRA = 2'd2;
   localparam logic [1:0] SZ_OCTA  = 2'd3;

   localparam logic [2:0] F_NONE    = 3'd0;
   localparam logic [2:0] F_ILLEGAL = 3'd1;
   localparam logic [2:0] F_ALIGN   = 3'd2;
   localparam logic [2:0] F_BUS     = 3'd3;
   localparam logic [2:0] F_TMO     = 3'd4;

   typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_CALC, ST_WR, ST_RESP} state_t;

   function automatic logic is_amo_op(input logic [4:0] op);
      case (op)
         AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR, AMO_SHL, AMO_SHR,
         AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] a, input logic [1:0] sz);
      case (sz)
         SZ_BYTE:  return 1'b0;
         SZ_WYDE:  return a[0];
         SZ_TETRA: return |a[1:0];
         default:  return |a;
      endcase
   endfunction

   function automatic logic [7:0] sel_gen(input logic [2:0] a, input logic [1:0] sz);
      case (sz)
         SZ_BYTE:  return 8'h01 << a;
         SZ_WYDE:  return 8'h03 << a;
         SZ_TETRA: return 8'h0F << a;
         default:  return 8'hFF;
      endcase
   endfunction

   function automatic logic [63:0] replicate(input logic [63:0] v, input logic [1:0] sz);
      case (sz)
         SZ_BYTE:  return {8{v[7:0]}};
         SZ_WYDE:  return {4{v[15:0]}};
         SZ_TETRA: return {2{v[31:0]}};
         default:  return v;
      endcase
   endfunction

   function automatic logic [63:0] lane_extract(input logic [63:0] v, input logic [2:0] a,
                                               input logic [1:0] sz, input logic zx);
      logic [63:0] s;
      s = v >> {a, 3'b000};
      case (sz)
         SZ_BYTE:  return zx ? {56'd0, s[7:0]}  : {{56{s[7]}}, s[7:0]};
         SZ_WYDE:  return zx ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
         SZ_TETRA: return zx ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
         default:  return s;
      endcase
   endfunction

endpackage

// File: rtl/ft64_amo_alu.sv
// FT64 AMO ALU: combinational, applies op independently in every lane of the
// given size, so whichever lane the bus selected carries the correct result.
module ft64_amo_alu
   import ft64_amo_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [1:0]  size,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic [63:0] res
);

   function automatic logic [63:0] lane_op(input logic [4:0] o, input int w,
                                           input logic [63:0] x, input logic [63:0] y);
      logic [63:0] msk, za, zb, sa, sb, sh, r;
      msk = (64'd1 << w) - 64'd1;
      za  = x & msk;
      zb  = y & msk;
      // sign-extend to 64 bits so one signed compare serves every width
      sa  = (|(za & ~(msk >> 1))) ? (za | ~msk) : za;
      sb  = (|(zb & ~(msk >> 1))) ? (zb | ~msk) : zb;
      sh  = zb & 64'(w - 1);
      case (o)
         AMO_SWAP: r = zb;
         AMO_ADD:  r = za + zb;
         AMO_AND:  r = za & zb;
         AMO_OR:   r = za | zb;
         AMO_XOR:  r = za ^ zb;
         AMO_SHL:  r = za << sh;
         AMO_SHR:  r = za >> sh;
         AMO_MIN:  r = ($signed(sa) < $signed(sb)) ? za : zb;
         AMO_MAX:  r = ($signed(sa) > $signed(sb)) ? za : zb;
         AMO_MINU: r = (za < zb) ? za : zb;
         AMO_MAXU: r = (za > zb) ? za : zb;
         default:  r = za;
      endcase
      return r & msk;
   endfunction

   int w;

   always_comb begin
      w   = 8 << size;
      res = '0;
      for (int i = 0; i < 8; i++) begin
         if (i * w < 64)
            res = res | (lane_op(op, w, a >> (i * w), b >> (i * w)) << (i * w));
      end
   end

endmodule

// File: rtl/ft64_amo_sequencer.sv
// Locked read-modify-write Wishbone engine for FT64 AMOs; one op in flight,
// old value returned with a fault code, bus held locked from read to write ack.
module ft64_amo_sequencer
   import ft64_amo_pkg::*;
#(
   parameter int AMSB = 31,
   parameter int TMO  = 255
)(
   input  logic          rst_i,
   input  logic          clk_i,
   input  logic          req_i,
   output logic          req_rdy_o,
   input  logic [31:0]   instr_i,
   input  logic [AMSB:0] adr_i,
   input  logic [63:0]   b_i,
   input  logic [4:0]    id_i,
   output logic          resp_valid_o,
   input  logic          resp_ready_i,
   output logic [4:0]    resp_id_o,
   output logic [63:0]   resp_dat_o,
   output logic [2:0]    resp_fault_o,
   output logic          cyc_o,
   output logic          stb_o,
   output logic          lock_o,
   output logic          we_o,
   output logic [7:0]    sel_o,
   output logic [AMSB:0] adr_o,
   output logic [63:0]   dat_o,
   input  logic          ack_i,
   input  logic          err_i,
   input  logic [63:0]   dat_i
);

   localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

   state_t      state;
   logic [4:0]  op;
   logic [1:0]  size;
   logic        zext;
   logic [2:0]  lo;
   logic [63:0] b;
   logic [63:0] old;
   logic [63:0] b_rep;
   logic [63:0] alu_res;
   logic [7:0]  tmo_cnt;
   logic        unused_instr;

   assign unused_instr = ^{instr_i[31], instr_i[25:24], instr_i[20:0]};
   assign b_rep        = replicate(b, size);

   ft64_amo_alu u_alu (
      .op   (op),
      .size (size),
      .a    (old),
      .b    (b_rep),
      .res  (alu_res)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= ST_IDLE;
         req_rdy_o    <= 1'b1;
         resp_valid_o <= 1'b0;
         resp_id_o    <= '0;
         resp_dat_o   <= '0;
         resp_fault_o <= F_NONE;
         cyc_o        <= 1'b0;
         stb_o        <= 1'b0;
         lock_o       <= 1'b0;
         we_o         <= 1'b0;
         sel_o        <= '0;
         adr_o        <= '0;
         dat_o        <= '0;
         op           <= '0;
         size         <= '0;
         zext         <= 1'b0;
         lo           <= '0;
         b            <= '0;
         old          <= '0;
         tmo_cnt      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_i && req_rdy_o) begin
                  op        <= instr_i[30:26];
                  size      <= instr_i[22:21];
                  zext      <= instr_i[23];
                  lo        <= adr_i[2:0];
                  b         <= b_i;
                  resp_id_o <= id_i;
                  req_rdy_o <= 1'b0;
                  sel_o     <= sel_gen(adr_i[2:0], instr_i[22:21]);
                  adr_o     <= {adr_i[AMSB:3], 3'b000};
                  if (!is_amo_op(instr_i[30:26]) || misaligned(adr_i[2:0], instr_i[22:21])) begin
                     resp_fault_o <= is_amo_op(instr_i[30:26]) ? F_ALIGN : F_ILLEGAL;
                     resp_dat_o   <= '0;
                     resp_valid_o <= 1'b1;
                     state        <= ST_RESP;
                  end else begin
                     cyc_o   <= 1'b1;
                     stb_o   <= 1'b1;
                     lock_o  <= 1'b1;
                     we_o    <= 1'b0;
                     tmo_cnt <= '0;
                     state   <= ST_RD;
                  end
               end
            end
            ST_RD: begin
               if (err_i || (!ack_i && tmo_cnt == TMO_LAST)) begin
                  cyc_o        <= 1'b0;
                  stb_o        <= 1'b0;
                  lock_o       <= 1'b0;
                  resp_fault_o <= err_i ? F_BUS : F_TMO;
                  resp_dat_o   <= '0;
                  resp_valid_o <= 1'b1;
                  state        <= ST_RESP;
               end else if (ack_i) begin
                  old   <= dat_i;
                  stb_o <= 1'b0;
                  state <= ST_CALC;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            // cyc/lock stay asserted so the location remains reserved
            ST_CALC: begin
               dat_o   <= alu_res;
               stb_o   <= 1'b1;
               we_o    <= 1'b1;
               tmo_cnt <= '0;
               state   <= ST_WR;
            end
            ST_WR: begin
               if (err_i || ack_i || tmo_cnt == TMO_LAST) begin
                  cyc_o        <= 1'b0;
                  stb_o        <= 1'b0;
                  lock_o       <= 1'b0;
                  we_o         <= 1'b0;
                  resp_fault_o <= err_i ? F_BUS : (ack_i ? F_NONE : F_TMO);
                  resp_dat_o   <= lane_extract(old, lo, size, zext);
                  resp_valid_o <= 1'b1;
                  state        <= ST_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            ST_RESP: begin
               if (resp_ready_i) begin
                  resp_valid_o <= 1'b0;
                  req_rdy_o    <= 1'b1;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
